// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access ops, memory command codes, FSM states.
package lsu_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'b000,
      OP_LBU = 3'b001,
      OP_LW  = 3'b010,
      OP_SB  = 3'b100,
      OP_SW  = 3'b110
   } op_e;

   localparam logic [1:0] MEM_IDLE = 2'b00;
   localparam logic [1:0] MEM_BYTE = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ISSUE   = 2'b01,
      CAPTURE = 2'b10,
      RESP    = 2'b11
   } state_e;

endpackage

// File: rtl/load_extend.sv
// Shapes raw memory read data into a load result: word pass-through, byte sign/zero extension.
module load_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] word,
   output logic [31:0] data_c
);

   always_comb begin
      data_c = '0;
      case (op)
         OP_LB:   data_c = {{24{word[7]}}, word[7:0]};
         OP_LBU:  data_c = {24'b0, word[7:0]};
         OP_LW:   data_c = word;
         default: data_c = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: checks each request, issues one memory cycle,
// captures load data and holds the response until the pipeline takes it.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic [1:0]  mem_read,
   output logic [1:0]  mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_word_in,
   input  logic [31:0] mem_word_out
);

   localparam logic [31:0] WORD_MAX = 32'(MEM_BYTES - 4);
   localparam logic [31:0] BYTE_MAX = 32'(MEM_BYTES - 1);

   state_e      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic        req_ready_d, resp_valid_d, resp_err_d;
   logic [31:0] resp_data_d, mem_address_d, mem_word_in_d;
   logic [1:0]  mem_read_d, mem_write_d;
   logic [31:0] load_data_c;
   logic        is_load_c, is_store_c, is_word_c, legal_c;

   load_extend u_load_extend (
      .op     (op_q),
      .word   (mem_word_out),
      .data_c (load_data_c)
   );

   // Request decode and legality (alignment, range, defined op)
   always_comb begin
      is_load_c  = 1'b0;
      is_store_c = 1'b0;
      is_word_c  = 1'b0;
      case (req_op)
         OP_LB, OP_LBU: is_load_c = 1'b1;
         OP_LW: begin
            is_load_c = 1'b1;
            is_word_c = 1'b1;
         end
         OP_SB: is_store_c = 1'b1;
         OP_SW: begin
            is_store_c = 1'b1;
            is_word_c  = 1'b1;
         end
         default: ;
      endcase
      if (is_word_c)
         legal_c = (req_addr[1:0] == 2'b00) && (req_addr <= WORD_MAX);
      else
         legal_c = (is_load_c || is_store_c) && (req_addr <= BYTE_MAX);
   end

   // Next state and next registered outputs; memory commands are one-cycle pulses
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      resp_valid_d  = resp_valid;
      resp_data_d   = resp_data;
      resp_err_d    = resp_err;
      mem_address_d = mem_address;
      mem_word_in_d = mem_word_in;
      mem_read_d    = MEM_IDLE;
      mem_write_d   = MEM_IDLE;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d = req_op;
               if (legal_c) begin
                  mem_address_d = req_addr;
                  if (is_store_c) begin
                     mem_word_in_d = is_word_c ? req_wdata : {24'b0, req_wdata[7:0]};
                     mem_write_d   = is_word_c ? MEM_WORD : MEM_BYTE;
                  end else begin
                     mem_read_d = is_word_c ? MEM_WORD : MEM_BYTE;
                  end
                  state_d = ISSUE;
               end else begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_data_d  = '0;
                  state_d      = RESP;
               end
            end
         end
         ISSUE: begin
            if (op_q == OP_SB || op_q == OP_SW) begin
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_data_d  = '0;
               state_d      = RESP;
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_data_d  = load_data_c;
            state_d      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_data_d  = '0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= OP_LB;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_data   <= '0;
         resp_err    <= 1'b0;
         mem_read    <= MEM_IDLE;
         mem_write   <= MEM_IDLE;
         mem_address <= '0;
         mem_word_in <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         req_ready   <= req_ready_d;
         resp_valid  <= resp_valid_d;
         resp_data   <= resp_data_d;
         resp_err    <= resp_err_d;
         mem_read    <= mem_read_d;
         mem_write   <= mem_write_d;
         mem_address <= mem_address_d;
         mem_word_in <= mem_word_in_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: 64-byte synchronous memory, per-cycle reference model, directed and random requests.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_data;
   logic [1:0]  mem_read, mem_write;
   logic [31:0] mem_address, mem_word_in, mem_word_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_BYTES(64)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_err     (resp_err),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_word_in  (mem_word_in),
      .mem_word_out (mem_word_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Attached memory: big-endian words, read data valid after the edge that samples mem_read
   logic [7:0] bmem [64];
   bit         bmem_init = 1'b0;
   always @(posedge clk) begin
      if (!bmem_init) begin
         for (int i = 0; i < 64; i++) bmem[i] <= 8'(i * 37 + 11);
         bmem_init <= 1'b1;
      end else begin
         if (mem_write == 2'b01)
            bmem[mem_address[5:0]] <= mem_word_in[7:0];
         else if (mem_write == 2'b11) begin
            bmem[mem_address[5:0]]         <= mem_word_in[31:24];
            bmem[6'(mem_address[5:0] + 1)] <= mem_word_in[23:16];
            bmem[6'(mem_address[5:0] + 2)] <= mem_word_in[15:8];
            bmem[6'(mem_address[5:0] + 3)] <= mem_word_in[7:0];
         end
         if (mem_read == 2'b01)
            mem_word_out <= {24'b0, bmem[mem_address[5:0]]};
         else if (mem_read == 2'b11)
            mem_word_out <= {bmem[mem_address[5:0]], bmem[6'(mem_address[5:0] + 1)],
                             bmem[6'(mem_address[5:0] + 2)], bmem[6'(mem_address[5:0] + 3)]};
      end
   end

   // Reference model: a transaction's age counts edges since acceptance.
   // Age 1: the single memory cycle; response from age 1 (illegal), 2 (store) or 3 (load).
   logic [7:0]  m_mem [64];
   bit          m_init = 1'b0;
   bit          m_busy = 1'b0;
   int          m_age, m_resp_age;
   bit          m_legal, m_load, m_word;
   logic [2:0]  m_op;
   logic [31:0] m_addr, m_wdata, m_data;

   always @(negedge clk) begin : model
      bit         acc, vis, known;
      logic [1:0] code;
      int         a;
      if (!m_init) begin
         for (int i = 0; i < 64; i++) m_mem[i] = 8'(i * 37 + 11);
         m_init = 1'b1;
      end
      if (!rst_n) begin
         chk("rst_resp_valid", resp_valid, 0);
         chk("rst_resp_err", resp_err, 0);
         chk("rst_resp_data", resp_data, 0);
         chk("rst_mem_read", mem_read, 0);
         chk("rst_mem_write", mem_write, 0);
         chk("rst_mem_address", mem_address, 0);
         chk("rst_mem_word_in", mem_word_in, 0);
         m_busy = 1'b0;
      end else begin
         acc  = m_busy && m_age == 1 && m_legal;
         vis  = m_busy && m_age >= m_resp_age;
         code = m_word ? 2'b11 : 2'b01;
         chk("req_ready", req_ready, !m_busy);
         chk("mem_read", mem_read, (acc && m_load) ? code : 2'b00);
         chk("mem_write", mem_write, (acc && !m_load) ? code : 2'b00);
         chk("mem_exclusive", (mem_read != 2'b00) && (mem_write != 2'b00), 0);
         if (acc) chk("mem_address", mem_address, m_addr);
         if (acc && !m_load)
            chk("mem_word_in", m_word ? mem_word_in : {24'b0, mem_word_in[7:0]},
                m_word ? m_wdata : {24'b0, m_wdata[7:0]});
         chk("resp_valid", resp_valid, vis);
         if (vis) begin
            chk("resp_data", resp_data, m_data);
            chk("resp_err", resp_err, !m_legal);
         end
         if (!m_busy) begin
            if (req_valid) begin
               m_op    = req_op;
               m_addr  = req_addr;
               m_wdata = req_wdata;
               known   = m_op inside {OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW};
               m_word  = (m_op == OP_LW) || (m_op == OP_SW);
               m_load  = (m_op == OP_LB) || (m_op == OP_LBU) || (m_op == OP_LW);
               m_legal = known && (m_word ? (m_addr[1:0] == 2'b00 && m_addr <= 32'd60)
                                          : (m_addr <= 32'd63));
               m_data  = 32'd0;
               a       = int'(m_addr[5:0]);
               if (m_legal) begin
                  case (m_op)
                     OP_LW:  m_data = {m_mem[a], m_mem[a + 1], m_mem[a + 2], m_mem[a + 3]};
                     OP_LB:  m_data = 32'($signed(m_mem[a]));
                     OP_LBU: m_data = 32'(m_mem[a]);
                     OP_SB:  m_mem[a] = m_wdata[7:0];
                     OP_SW: begin
                        m_mem[a]     = m_wdata[31:24];
                        m_mem[a + 1] = m_wdata[23:16];
                        m_mem[a + 2] = m_wdata[15:8];
                        m_mem[a + 3] = m_wdata[7:0];
                     end
                     default: ;
                  endcase
               end
               m_resp_age = !m_legal ? 1 : (m_load ? 3 : 2);
               m_age      = 1;
               m_busy     = 1'b1;
            end
         end else if (vis && resp_ready) begin
            m_busy = 1'b0;
         end else begin
            m_age++;
         end
      end
   end

   // Issue one request, hold resp_ready low for 'hold' visible response cycles; called at posedge+1
   task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, input bit keep,
                         output logic [31:0] data, output logic err, output int lat);
      int  n, seen;
      bit  done;
      req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      resp_ready = (hold == 0);
      data = '0; err = 1'b0; lat = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 50);
      if (!req_ready) begin
         chk("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (!keep) req_valid = 1'b0;
      n = 0; seen = 0; done = 1'b0;
      while (!done && n < 60) begin
         @(negedge clk); n++;
         if (resp_valid) begin
            seen++;
            if (seen == 1) lat = n;
            if (seen > hold) done = 1'b1;
            else begin
               chk("hold_req_ready", req_ready, 0);
               @(posedge clk); #1;
               if (seen == hold) resp_ready = 1'b1;
            end
         end
      end
      if (!done) begin
         chk("resp_timeout", 0, 1);
         resp_ready = 1'b1;
         return;
      end
      data = resp_data;
      err  = resp_err;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] d, w, a;
      logic        e;
      int          lat, n, r;
      logic [2:0]  op;

      rst_n = 1'b0; req_valid = 1'b0; req_op = 3'b000; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b1;
      #1;
      chk("por_resp_valid", resp_valid, 0);
      chk("por_mem_read", mem_read, 0);
      chk("por_mem_write", mem_write, 0);
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b1;
      chk("ready_after_reset", req_ready, 1);

      // Word store then load
      do_req(OP_SW, 32'd8, 32'h11223344, 0, 0, d, e, lat);
      chk("sw8_err", e, 0); chk("sw8_data", d, 0); chk("sw8_lat", lat, 2);
      do_req(OP_LW, 32'd8, 32'h0, 0, 0, d, e, lat);
      chk("lw8_data", d, 32'h11223344); chk("lw8_err", e, 0); chk("lw8_lat", lat, 3);

      // Byte store, signed and unsigned byte loads
      do_req(OP_SB, 32'd5, 32'hABCD_EF80, 0, 0, d, e, lat);
      chk("model_mem5", m_mem[5], 32'h80);
      do_req(OP_LB, 32'd5, 32'h0, 0, 0, d, e, lat);
      chk("lb5_data", d, 32'hFFFFFF80);
      do_req(OP_LBU, 32'd5, 32'h0, 0, 0, d, e, lat);
      chk("lbu5_data", d, 32'h00000080);

      // Illegal: misaligned, word past end, byte past end, undefined op
      do_req(OP_LW, 32'd6, 32'h0, 0, 0, d, e, lat);
      chk("lw6_err", e, 1); chk("lw6_data", d, 0); chk("lw6_lat", lat, 1);
      do_req(OP_SW, 32'd61, 32'hDEADBEEF, 0, 0, d, e, lat);
      chk("sw61_err", e, 1); chk("sw61_data", d, 0);
      do_req(OP_LB, 32'd64, 32'h0, 0, 0, d, e, lat);
      chk("lb64_err", e, 1); chk("lb64_data", d, 0);
      do_req(OP_LB, 32'd63, 32'h0, 0, 0, d, e, lat);
      chk("lb63_err", e, 0);
      do_req(OP_LW, 32'd60, 32'h0, 0, 0, d, e, lat);
      chk("lw60_err", e, 0);
      do_req(3'b111, 32'd0, 32'h0, 0, 0, d, e, lat);
      chk("undef_err", e, 1);

      // Response back-pressure for four cycles
      do_req(OP_LW, 32'd0, 32'h0, 4, 0, d, e, lat);
      chk("lw0_hold_data", d, 32'h0B30557A); chk("lw0_hold_err", e, 0);

      // Reset while the load is in its capture cycle
      req_op = OP_LW; req_addr = 32'd8; req_valid = 1'b1; resp_ready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 20);
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_resp_valid", resp_valid, 0);
      chk("midrst_resp_data", resp_data, 0);
      chk("midrst_mem_read", mem_read, 0);
      chk("midrst_mem_address", mem_address, 0);
      chk("midrst_mem_word_in", mem_word_in, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      chk("midrst_ready", req_ready, 1);
      do_req(OP_LW, 32'd8, 32'h0, 0, 0, d, e, lat);
      chk("post_rst_lw8", d, 32'h11223344);

      // Back-to-back store/load pairs with req_valid held high
      for (int i = 0; i < 10; i++) begin
         a = 32'(4 * $urandom_range(0, 15));
         w = $urandom;
         do_req(OP_SW, a, w, 0, 1, d, e, lat);
         do_req(OP_LW, a, 32'h0, 0, (i != 9), d, e, lat);
         chk("pair_lw", d, w);
      end

      // Random traffic, checked by the model every cycle
      for (int i = 0; i < 150; i++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0: op = OP_LB;
            1: op = OP_LBU;
            2, 8: op = OP_LW;
            3: op = OP_SB;
            4, 9: op = OP_SW;
            5: op = 3'b011;
            6: op = 3'b101;
            default: op = 3'b111;
         endcase
         a = 32'($urandom_range(0, 67));
         if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
         if ($urandom_range(0, 15) == 0) a = $urandom;
         do_req(op, a, $urandom, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), d, e, lat);
         if ($urandom_range(0, 3) == 0) begin
            req_valid = 1'b0;
            req_op = 3'($urandom); req_addr = $urandom;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
      end
      req_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
